muldiv_hilo: RTL

Sequential multiply/divide unit for the 16-bit CPU. It sits between the execute stage and the combinational 16x16 unsigned array multiplier. It registers operands into the multiplier and captures the 32-bit product into architectural HI/LO registers. It also performs unsigned restoring division locally and supports direct HI/LO writes, giving the core a busy/done handshake to stall on.

---
 rtl/muldiv_hilo.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo.sv
// Purpose : sequential MUL (via external array multiplier), restoring DIV, MTHI/MTLO into HI/LO.
// Latency : MUL = MUL_WAIT cycles, DIV = 16 cycles, MTHI/MTLO = 0 (update at accept edge).
// Backpr. : start is only sampled while busy=0; starts during busy are dropped, never queued.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, op, a, b     request (op: 00 MUL, 01 DIV, 10 MTHI, 11 MTLO) and operands
//   busy, done          stall handshake; done is a one-cycle pulse on the HI/LO update
//   hi, lo, div_by_zero architectural results
//   mult_a, mult_b      registered operands to the external multiplier
//   mult_m, mult_n      low / high product back from the multiplier
module muldiv_hilo #(
  parameter int MUL_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] hi,
  output logic [15:0] lo,
  output logic        div_by_zero,
  output logic [15:0] mult_a,
  output logic [15:0] mult_b,
  input  logic [15:0] mult_m,
  input  logic [15:0] mult_n
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam logic [1:0] WAIT_INIT = 2'(MUL_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_wait;
  logic [3:0]  r_cnt;
  logic [15:0] r_dvd;
  logic [15:0] r_dvs;
  // The partial remainder is always below the divisor, so 16 bits hold it;
  // the 17th bit only exists in the trial value below.
  logic [15:0] r_rem;
  logic [15:0] r_quo;
  logic [15:0] r_hi, r_lo, r_mult_a, r_mult_b;
  logic        r_done, r_dbz;

  logic        w_accept;
  logic [16:0] w_trial;
  logic        w_ge;
  logic [15:0] w_rem_nxt;
  logic [15:0] w_quo_nxt;

  assign w_accept  = start && (r_state == S_IDLE);

  // One restoring step: bring down the next dividend bit and subtract if it fits.
  assign w_trial   = {r_rem, r_dvd[15]};
  assign w_ge      = (w_trial >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? 16'(w_trial - {1'b0, r_dvs}) : w_trial[15:0];
  assign w_quo_nxt = {r_quo[14:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && op == OP_MUL) w_state_nxt = S_MUL;
        if (w_accept && op == OP_DIV) w_state_nxt = S_DIV;
      end
      S_MUL:   if (r_wait == 2'd0) w_state_nxt = S_IDLE;
      S_DIV:   if (r_cnt == 4'd0)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait   <= '0;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mult_a <= '0;
      r_mult_b <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              OP_MUL: begin
                r_mult_a <= a;
                r_mult_b <= b;
                r_wait   <= WAIT_INIT;
              end
              OP_DIV: begin
                r_dvd <= a;
                r_dvs <= b;
                r_rem <= '0;
                r_quo <= '0;
                r_cnt <= 4'd15;
                r_dbz <= (b == 16'd0);
              end
              OP_MTHI: begin
                r_hi   <= a;
                r_done <= 1'b1;
              end
              OP_MTLO: begin
                r_lo   <= a;
                r_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (r_wait == 2'd0) begin
            r_lo   <= mult_m;
            r_hi   <= mult_n;
            r_done <= 1'b1;
          end else begin
            r_wait <= r_wait - 2'd1;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_dvd <= {r_dvd[14:0], 1'b0};
          r_cnt <= r_cnt - 4'd1;
          // Last step: publish this cycle's results, not the stale registers.
          if (r_cnt == 4'd0) begin
            r_lo   <= w_quo_nxt;
            r_hi   <= w_rem_nxt;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;
  assign mult_a      = r_mult_a;
  assign mult_b      = r_mult_b;

endmodule
